// File: rtl/ascii_adder_pkg.sv
// rtl/ascii_adder_pkg.sv - shared state encoding and ASCII constants for the ASCII adder controller
package ascii_adder_pkg;

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        ADD,
        SEND,
        ERR
    } state_t;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_EQ   = 8'h3D;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_QM   = 8'h3F;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// rtl/bcd_digit_adder.sv - single-digit BCD adder with carry in/out
module bcd_digit_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [4:0] w_raw;
    logic       w_adj;

    assign w_raw  = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
    assign w_adj  = (w_raw > 5'd9);
    // Adding 6 modulo 16 folds a 10..19 raw sum back into 0..9.
    assign o_sum  = w_raw[3:0] + (w_adj ? 4'd6 : 4'd0);
    assign o_cout = w_adj;

endmodule

// File: rtl/ascii_adder_ctrl.sv
// rtl/ascii_adder_ctrl.sv - parses "<A>+<B>=", adds BCD digits LSD first, streams the sum + CR
// Optional feature macro: ASCII_ECHO_EN (echo every accepted input character).
module ascii_adder_ctrl
    import ascii_adder_pkg::*;
#(
    parameter int N_DIGITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_char,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);

    localparam int CW = $clog2(N_DIGITS + 1);

    state_t                    r_state, w_state_nxt;
    logic [N_DIGITS-1:0][3:0]  r_a, r_b;
    logic [N_DIGITS:0][3:0]    r_res;
    logic [CW-1:0]             r_cnt_a, r_cnt_b, r_idx, r_pos;
    logic                      r_carry, r_started, r_cr;
    logic [7:0]                r_out_char;
    logic                      r_out_valid, r_err;

    logic                      w_get, w_in_fire, w_out_fire, w_digit_ok;
    logic [CW-1:0]             w_cnt, w_msd, w_next_pos;
    logic [7:0]                w_term;
    logic [3:0]                w_da, w_db, w_sum, w_msd_dig, w_next_dig;
    logic                      w_cout;

    assign w_get      = (r_state == GET_A) || (r_state == GET_B);
`ifdef ASCII_ECHO_EN
    assign in_ready   = w_get && !r_out_valid;
`else
    assign in_ready   = w_get;
`endif
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_cnt      = (r_state == GET_B) ? r_cnt_b : r_cnt_a;
    assign w_term     = (r_state == GET_B) ? CH_EQ : CH_PLUS;
    assign w_digit_ok = is_digit(in_char) && (w_cnt != CW'(N_DIGITS));
    assign w_next_pos = r_pos - 1'b1;

    assign out_char   = r_out_char;
    assign out_valid  = r_out_valid;
    assign err        = r_err;
    assign busy       = (r_state == ADD) || (r_state == SEND);

    bcd_digit_adder u_add (
        .i_a    (w_da),
        .i_b    (w_db),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Digit muxes: adder operands, most significant non-zero result digit, next digit to send.
    always_comb begin
        w_da       = 4'd0;
        w_db       = 4'd0;
        w_msd      = '0;
        w_msd_dig  = 4'd0;
        w_next_dig = 4'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == CW'(i)) begin
                w_da = r_a[i];
                w_db = r_b[i];
            end
        end
        for (int i = 0; i <= N_DIGITS; i++) begin
            if (r_res[i] != 4'd0) w_msd = CW'(i);
        end
        for (int i = 0; i <= N_DIGITS; i++) begin
            if (w_msd == CW'(i))      w_msd_dig  = r_res[i];
            if (w_next_pos == CW'(i)) w_next_dig = r_res[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            GET_A, GET_B: begin
                if (w_in_fire && !w_digit_ok) begin
                    if (in_char == w_term && w_cnt != '0)
                        w_state_nxt = (r_state == GET_A) ? GET_B : ADD;
                    else
                        w_state_nxt = ERR;
                end
            end
            ADD:       if (r_idx == CW'(N_DIGITS - 1)) w_state_nxt = SEND;
            SEND, ERR: if (w_out_fire && r_cr) w_state_nxt = GET_A;
            default:   w_state_nxt = GET_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= GET_A;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_cnt_a     <= '0;
            r_cnt_b     <= '0;
            r_idx       <= '0;
            r_pos       <= '0;
            r_carry     <= 1'b0;
            r_started   <= 1'b0;
            r_cr        <= 1'b0;
            r_out_char  <= 8'h00;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= (w_state_nxt == ERR) && (r_state != ERR);
            if (w_out_fire) r_out_valid <= 1'b0;
            case (r_state)
                GET_A, GET_B: begin
                    if (w_in_fire) begin
`ifdef ASCII_ECHO_EN
                        r_out_char  <= in_char;
                        r_out_valid <= 1'b1;
`endif
                        if (w_digit_ok && r_state == GET_A) begin
                            r_a     <= {r_a[N_DIGITS-2:0], in_char[3:0]};
                            r_cnt_a <= r_cnt_a + 1'b1;
                        end else if (w_digit_ok) begin
                            r_b     <= {r_b[N_DIGITS-2:0], in_char[3:0]};
                            r_cnt_b <= r_cnt_b + 1'b1;
                        end
                    end
                end
                ADD: begin
                    for (int i = 0; i < N_DIGITS; i++) begin
                        if (r_idx == CW'(i)) r_res[i] <= w_sum;
                    end
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == CW'(N_DIGITS - 1)) r_res[N_DIGITS] <= {3'b000, w_cout};
                end
                SEND, ERR: begin
                    // First character waits until any pending echo has been taken.
                    if (!r_started) begin
                        if (!r_out_valid || out_ready) begin
                            r_out_char  <= (r_state == SEND) ? (CH_0 | {4'h0, w_msd_dig}) : CH_QM;
                            r_pos       <= (r_state == SEND) ? w_msd : '0;
                            r_out_valid <= 1'b1;
                            r_started   <= 1'b1;
                        end
                    end else if (w_out_fire) begin
                        if (r_cr) begin
                            r_a       <= '0;
                            r_b       <= '0;
                            r_res     <= '0;
                            r_cnt_a   <= '0;
                            r_cnt_b   <= '0;
                            r_idx     <= '0;
                            r_pos     <= '0;
                            r_carry   <= 1'b0;
                            r_started <= 1'b0;
                            r_cr      <= 1'b0;
                        end else if (r_pos == '0) begin
                            r_out_char  <= CH_CR;
                            r_out_valid <= 1'b1;
                            r_cr        <= 1'b1;
                        end else begin
                            r_pos       <= w_next_pos;
                            r_out_char  <= CH_0 | {4'h0, w_next_dig};
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
